// File: rtl/dispatch_sched.sv
// Dispatch scheduler: 2-entry decode buffer, steers head to a reservation station by class, allocates a ROB tag.
// Enqueue-to-dispatch latency is 1 cycle; stall when the buffer is full, and the head blocks on ROB or target RS full.
module dispatch_sched #(
  parameter int INSTR_W   = 32,
  parameter int ROB_TAG_W = 5,
  parameter int CNT_W     = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 dec_valid,
  input  logic [INSTR_W-1:0]   dec_instr,
  input  logic [2:0]           dec_class,
  output logic                 stall,
  input  logic                 flush,
  input  logic                 robFull,
  input  logic [ROB_TAG_W-1:0] rob_tail_tag,
  output logic                 rob_alloc,
  input  logic                 aluFull,
  input  logic                 brnchFull,
  input  logic                 mulDivFull,
  input  logic                 lwFull,
  input  logic                 swFull,
  output logic [4:0]           disp_valid,
  output logic [INSTR_W-1:0]   disp_instr,
  output logic [ROB_TAG_W-1:0] disp_tag,
  output logic [2:0]           stall_cause,
  output logic [CNT_W-1:0]     stall_cycles
);

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [2:0]         cls;
  } entry_t;

  entry_t     buf_q [2];
  logic       rd_ptr, wr_ptr;
  logic [1:0] count;

  entry_t     head;
  logic [2:0] head_cls;
  logic [4:0] rs_full;
  logic       head_valid, go, enq, blocked;

  assign head       = buf_q[rd_ptr];
  // Reserved classes 5-7 execute on the ALU station.
  assign head_cls   = (head.cls > 3'd4) ? 3'd0 : head.cls;
  assign rs_full    = {swFull, lwFull, mulDivFull, brnchFull, aluFull};
  assign head_valid = (count != 2'd0);
  assign stall      = (count == 2'd2);
  assign go         = head_valid & ~flush & ~robFull & ~rs_full[head_cls];
  assign enq        = dec_valid & ~stall & ~flush;
  assign blocked    = head_valid & ~flush & ~go;

  assign rob_alloc  = go;
  assign disp_valid = go ? (5'b00001 << head_cls) : 5'b00000;
  assign disp_instr = head.instr;
  assign disp_tag   = rob_tail_tag;

  always_comb begin
    stall_cause = 3'd0;
    if (head_valid && !flush) begin
      if (robFull)
        stall_cause = 3'd1;
      else if (rs_full[head_cls])
        stall_cause = 3'd2 + head_cls;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else if (flush) begin
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else begin
      if (enq) wr_ptr <= ~wr_ptr;
      if (go)  rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, enq} - {1'b0, go};
    end
  end

  // Payload storage needs no reset; count gates every use of it.
  always_ff @(posedge clk) begin
    if (enq)
      buf_q[wr_ptr] <= '{instr: dec_instr, cls: dec_class};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      stall_cycles <= '0;
    else if (blocked && (stall_cycles != {CNT_W{1'b1}}))
      stall_cycles <= stall_cycles + CNT_W'(1);
  end

endmodule

// File: tb/tb_dispatch_sched.sv
// Directed plus randomized bench for dispatch_sched against a queue-based reference model.
module tb_dispatch_sched;
  localparam int INSTR_W = 32;
  localparam int TAG_W   = 5;
  localparam int CNT_W   = 4;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               dec_valid = 1'b0;
  logic [INSTR_W-1:0] dec_instr = '0;
  logic [2:0]         dec_class = '0;
  logic               stall;
  logic               flush = 1'b0;
  logic               robFull = 1'b0;
  logic [TAG_W-1:0]   rob_tail_tag = '0;
  logic               rob_alloc;
  logic               aluFull = 1'b0, brnchFull = 1'b0, mulDivFull = 1'b0, lwFull = 1'b0, swFull = 1'b0;
  logic [4:0]         disp_valid;
  logic [INSTR_W-1:0] disp_instr;
  logic [TAG_W-1:0]   disp_tag;
  logic [2:0]         stall_cause;
  logic [CNT_W-1:0]   stall_cycles;

  dispatch_sched #(.INSTR_W(INSTR_W), .ROB_TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .dec_valid(dec_valid), .dec_instr(dec_instr),
    .dec_class(dec_class), .stall(stall), .flush(flush), .robFull(robFull),
    .rob_tail_tag(rob_tail_tag), .rob_alloc(rob_alloc), .aluFull(aluFull),
    .brnchFull(brnchFull), .mulDivFull(mulDivFull), .lwFull(lwFull), .swFull(swFull),
    .disp_valid(disp_valid), .disp_instr(disp_instr), .disp_tag(disp_tag),
    .stall_cause(stall_cause), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [INSTR_W-1:0] instr;
    int                 cls;
  } ent_t;

  ent_t mq[$];
  int   m_cnt = 0;
  int   checks = 0;
  int   errors = 0;
  bit   g;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int target(input int c);
    return (c > 4) ? 0 : c;
  endfunction

  // Compares every output against what the queue model says for the current inputs.
  task automatic check_outputs(output bit go_o);
    logic [4:0] fv;
    int t, cause;
    fv = {swFull, lwFull, mulDivFull, brnchFull, aluFull};
    t = (mq.size() > 0) ? target(mq[0].cls) : 0;
    go_o = (mq.size() > 0) && !flush && !robFull && !fv[t];
    if (mq.size() == 0 || flush) cause = 0;
    else if (robFull)            cause = 1;
    else if (fv[t])              cause = 2 + t;
    else                         cause = 0;
    check("stall",        32'(stall),        32'(mq.size() == 2));
    check("rob_alloc",    32'(rob_alloc),    32'(go_o));
    check("disp_valid",   32'(disp_valid),   go_o ? (32'd1 << t) : 32'd0);
    check("stall_cause",  32'(stall_cause),  32'(cause));
    check("stall_cycles", 32'(stall_cycles), 32'(m_cnt));
    if (go_o) begin
      check("disp_instr", disp_instr, mq[0].instr);
      check("disp_tag",   32'(disp_tag), 32'(rob_tail_tag));
    end
  endtask

  task automatic model_edge(input bit go_i);
    int sz;
    if (mq.size() > 0 && !flush && !go_i && m_cnt < 15) m_cnt++;
    if (flush) mq.delete();
    else begin
      sz = mq.size();
      if (go_i) void'(mq.pop_front());
      if (dec_valid && sz < 2) mq.push_back('{instr: dec_instr, cls: int'(dec_class)});
    end
  endtask

  task automatic tick();
    check_outputs(g);
    @(posedge clk);
    model_edge(g);
    #1;
  endtask

  task automatic cycle();
    @(negedge clk);
    tick();
  endtask

  // Asserts reset asynchronously, checks outputs a moment later, releases just after the next edge.
  task automatic do_reset();
    reset = 1'b1;
    mq.delete();
    m_cnt = 0;
    #1;
    check_outputs(g);
    check("rst_stall_cycles", 32'(stall_cycles), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic all_clear();
    dec_valid = 0; flush = 0; robFull = 0;
    aluFull = 0; brnchFull = 0; mulDivFull = 0; lwFull = 0; swFull = 0;
  endtask

  task automatic enq(input int cls, input logic [31:0] instr);
    dec_valid = 1; dec_class = 3'(cls); dec_instr = instr;
  endtask

  initial begin
    // 1: basic single dispatch
    do_reset();
    enq(0, 32'h11); rob_tail_tag = 5'd3;
    cycle();
    dec_valid = 0;
    @(negedge clk);
    check("t1_disp_valid", 32'(disp_valid), 32'h1);
    check("t1_rob_alloc",  32'(rob_alloc),  32'h1);
    check("t1_disp_tag",   32'(disp_tag),   32'h3);
    check("t1_disp_instr", disp_instr,      32'h11);
    tick();
    cycle();

    // 2: MULDIV blocked, buffer fills, then releases MULDIV then LW
    do_reset();
    mulDivFull = 1;
    enq(2, 32'h22); cycle();
    enq(3, 32'h33); cycle();
    dec_valid = 0;
    @(negedge clk);
    check("t2_stall",       32'(stall),       32'h1);
    check("t2_stall_cause", 32'(stall_cause), 32'h4);
    tick();
    repeat (4) cycle();
    mulDivFull = 0;
    @(negedge clk);
    check("t2_muldiv", 32'(disp_valid), 32'h04);
    tick();
    @(negedge clk);
    check("t2_lw", 32'(disp_valid), 32'h08);
    check("t2_cnt", 32'(stall_cycles), 32'd6);
    tick();
    cycle();

    // 3: ROB full outranks RS full
    do_reset();
    robFull = 1; aluFull = 1;
    enq(0, 32'h44); cycle();
    dec_valid = 0;
    @(negedge clk);
    check("t3_cause", 32'(stall_cause), 32'h1);
    check("t3_alloc", 32'(rob_alloc),   32'h0);
    tick();
    cycle();
    all_clear();
    cycle(); cycle();

    // 4: flush while full and decode valid
    do_reset();
    aluFull = 1;
    enq(0, 32'h55); cycle();
    enq(1, 32'h66); cycle();
    flush = 1; enq(4, 32'h77); cycle();
    flush = 0; dec_valid = 0;
    @(negedge clk);
    check("t4_stall", 32'(stall), 32'h0);
    tick();
    cycle();
    all_clear();

    // 5: continuous stream, one dispatch per cycle, class 7 routed to ALU
    do_reset();
    for (int i = 0; i < 20; i++) begin
      enq((i == 12) ? 7 : i % 5, 32'h1000 + i);
      rob_tail_tag = 5'(i + 7);
      cycle();
    end
    dec_valid = 0;
    cycle(); cycle();

    // 6: saturating counter, then reset mid-block
    do_reset();
    aluFull = 1;
    enq(0, 32'h88); cycle();
    dec_valid = 0;
    repeat (20) cycle();
    @(negedge clk);
    check("t6_sat", 32'(stall_cycles), 32'hF);
    tick();
    #2;
    do_reset();
    all_clear();
    cycle();

    // Randomized traffic with one asynchronous reset in the middle
    for (int i = 0; i < 400; i++) begin
      dec_valid    = ($urandom % 4) != 0;
      dec_class    = 3'($urandom % 8);
      dec_instr    = $urandom;
      rob_tail_tag = 5'($urandom);
      robFull      = ($urandom % 5) == 0;
      aluFull      = ($urandom % 4) == 0;
      brnchFull    = ($urandom % 4) == 0;
      mulDivFull   = ($urandom % 3) == 0;
      lwFull       = ($urandom % 4) == 0;
      swFull       = ($urandom % 4) == 0;
      flush        = ($urandom % 16) == 0;
      if (i == 200) begin
        #2;
        do_reset();
      end
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
